// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator-domain divided-enable controller.
package osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } osc_state_t;

    localparam int SETTLE_DEFAULT = 16;

endpackage

// File: rtl/osc_div_ctrl.sv
// Divided clock-enable generator clocked by the oscillator itself: discards a
// settle window after enable, then emits one-cycle pulses every div+1 cycles.
module osc_div_ctrl
    import osc_pkg::*;
#(
    parameter int DIV_W         = 8,
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_en,
    output logic             ready,
    output logic             pend,
    output logic [15:0]      tick_cnt
);

    // One down-counter serves both the settle window and the divide period,
    // so it must be wide enough for either.
    localparam int CNT_W = (DIV_W > 16) ? DIV_W : 16;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    osc_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_active_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk_en;
    logic             r_ready;
    logic [15:0]      r_tick_cnt;

    logic             w_cnt_zero;
    logic [DIV_W-1:0] w_reload_div;
    logic [DIV_W-1:0] w_settle_div;

    // A load on the terminal-count edge wins over any older pending value.
    always_comb begin
        w_cnt_zero   = (r_cnt == '0);
        w_reload_div = r_active_div;
        if (div_load) begin
            w_reload_div = div_val;
        end else if (r_pend) begin
            w_reload_div = r_pend_div;
        end
        w_settle_div = div_load ? div_val : r_active_div;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_active_div <= '0;
            r_pend_div   <= '0;
            r_pend       <= 1'b0;
            r_clk_en     <= 1'b0;
            r_ready      <= 1'b0;
            r_tick_cnt   <= '0;
        end else if (!en) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_clk_en   <= 1'b0;
            r_ready    <= 1'b0;
            r_tick_cnt <= '0;
            if (div_load) begin
                r_active_div <= div_val;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_SETTLE;
                    r_cnt    <= SETTLE_LOAD;
                    r_clk_en <= 1'b0;
                    if (div_load) begin
                        r_active_div <= div_val;
                    end
                end
                ST_SETTLE: begin
                    r_clk_en <= 1'b0;
                    if (div_load) begin
                        r_active_div <= div_val;
                    end
                    if (w_cnt_zero) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                        r_cnt   <= CNT_W'(w_settle_div);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_cnt_zero) begin
                        r_clk_en     <= 1'b1;
                        r_tick_cnt   <= r_tick_cnt + 16'd1;
                        r_cnt        <= CNT_W'(w_reload_div);
                        r_active_div <= w_reload_div;
                        r_pend       <= 1'b0;
                    end else begin
                        r_clk_en <= 1'b0;
                        r_cnt    <= r_cnt - CNT_W'(1);
                        if (div_load) begin
                            r_pend_div <= div_val;
                            r_pend     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    r_pend   <= 1'b0;
                    r_clk_en <= 1'b0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en   = r_clk_en;
    assign ready    = r_ready;
    assign pend     = r_pend;
    assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_osc_div_ctrl.sv
// Directed bench for osc_div_ctrl: settle timing, divide periods, deferred
// divisor loads, tick counter wrap, enable drop and asynchronous reset.
module tb_osc_div_ctrl;

    localparam int DIV_W = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             div_load = 1'b0;
    logic             clk_en;
    logic             ready;
    logic             pend;
    logic [15:0]      tick_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    osc_div_ctrl #(
        .DIV_W         (DIV_W),
        .SETTLE_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_en   (clk_en),
        .ready    (ready),
        .pend     (pend),
        .tick_cnt (tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_clk_en"}, 32'(clk_en), 32'd0);
        check_val({tag, "_ready"}, 32'(ready), 32'd0);
        check_val({tag, "_pend"}, 32'(pend), 32'd0);
        check_val({tag, "_tick"}, 32'(tick_cnt), 32'd0);
    endtask

    // Call right after the edge that moved IDLE->SETTLE; ready must rise 16 edges later.
    task automatic settle_to_ready(input string tag);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_val({tag, "_ready_lo"}, 32'(ready), 32'd0);
            check_val({tag, "_no_pulse"}, 32'(clk_en), 32'd0);
        end
        tick();
        check_val({tag, "_ready_hi"}, 32'(ready), 32'd1);
        check_val({tag, "_clk_en"}, 32'(clk_en), 32'd0);
        check_val({tag, "_tick0"}, 32'(tick_cnt), 32'd0);
    endtask

    task automatic expect_period(input string tag, input int p, input int exp_tick);
        for (int i = 1; i < p; i++) begin
            tick();
            check_val({tag, "_gap"}, 32'(clk_en), 32'd0);
        end
        tick();
        check_val({tag, "_pulse"}, 32'(clk_en), 32'd1);
        check_val({tag, "_tick"}, 32'(tick_cnt), 32'(exp_tick));
    endtask

    initial begin
        // reset state
        #2;
        check_idle("reset");
        tick();
        tick();
        rst = 1'b0;

        // divisor 3 loaded in IDLE, then enable
        div_val  = 8'd3;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        en       = 1'b1;
        tick();
        check_val("idle_load_pend", 32'(pend), 32'd0);
        settle_to_ready("settle1");
        expect_period("div3_a", 4, 1);
        expect_period("div3_b", 4, 2);
        expect_period("div3_c", 4, 3);

        // deferred load of 7, two cycles after a pulse
        tick();
        check_val("pre_load_clk_en", 32'(clk_en), 32'd0);
        div_val  = 8'd7;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check_val("pend_set", 32'(pend), 32'd1);
        tick();
        check_val("pend_hold", 32'(pend), 32'd1);
        check_val("pend_hold_clk_en", 32'(clk_en), 32'd0);
        tick();
        check_val("apply7_pulse", 32'(clk_en), 32'd1);
        check_val("apply7_pend_clr", 32'(pend), 32'd0);
        check_val("apply7_tick", 32'(tick_cnt), 32'd4);
        expect_period("div7", 8, 5);

        // two loads while pending: last one (2) wins
        div_val  = 8'd5;
        div_load = 1'b1;
        tick();
        div_val = 8'd2;
        tick();
        div_load = 1'b0;
        check_val("lastwin_pend", 32'(pend), 32'd1);
        expect_period("lastwin_tc", 6, 6);
        check_val("lastwin_pend_clr", 32'(pend), 32'd0);
        expect_period("div2", 3, 7);

        // load of 0 on the terminal-count edge: immediate, never pending
        tick();
        tick();
        div_val  = 8'd0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check_val("tc_load_pulse", 32'(clk_en), 32'd1);
        check_val("tc_load_pend", 32'(pend), 32'd0);
        check_val("tc_load_tick", 32'(tick_cnt), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("div0_cont", 32'(clk_en), 32'd1);
            check_val("div0_pend", 32'(pend), 32'd0);
        end
        check_val("div0_tick", 32'(tick_cnt), 32'd13);

        // enable drop clears everything on the next edge
        en = 1'b0;
        tick();
        check_idle("en_drop");

        // tick counter wrap with divisor 0
        en = 1'b1;
        tick();
        settle_to_ready("settle2");
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check_val("wrap_pre", 32'(tick_cnt), 32'd65535);
        tick();
        check_val("wrap_zero", 32'(tick_cnt), 32'd0);
        check_val("wrap_pulse", 32'(clk_en), 32'd1);
        en = 1'b0;
        tick();
        check_idle("en_drop2");

        // asynchronous reset during SETTLE
        en = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_settle");
        tick();
        en       = 1'b0;
        rst      = 1'b0;
        div_val  = 8'd3;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        en       = 1'b1;
        tick();
        settle_to_ready("settle3");
        expect_period("div3_r", 4, 1);

        // asynchronous reset in RUN with a pending divisor
        tick();
        div_val  = 8'd5;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check_val("rst_run_pend_pre", 32'(pend), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_run");
        tick();
        check_idle("rst_run_held");
        rst = 1'b0;
        tick();
        settle_to_ready("settle4");
        tick();
        check_val("post_rst_div0", 32'(clk_en), 32'd1);
        check_val("post_rst_tick1", 32'(tick_cnt), 32'd1);
        tick();
        check_val("post_rst_div0_b", 32'(clk_en), 32'd1);
        check_val("post_rst_tick2", 32'(tick_cnt), 32'd2);

        // en 1->0->1 restarts a full settle window
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check_idle("toggle_idle");
        en = 1'b1;
        tick();
        settle_to_ready("settle5");
        tick();
        check_val("toggle_first_pulse", 32'(clk_en), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
